// File: rtl/priority_req_sched_if.sv
// priority_req_sched_if
// Bundles the request / grant handshake and status signals of priority_req_sched.
//   slave  : the scheduler (drives grant_*, pending_o, busy_o, grant_cnt_o)
//   master : the environment (drives req_i, grant_ready_i)
// Signals:
//   req_i          N_REQ  request pulses, bit k = source k
//   grant_ready_i  1      downstream accepts grant
//   grant_valid_o  1      grant offered
//   grant_idx_o    IDX_W  index of granted source
//   grant_onehot_o N_REQ  one-hot form of grant_idx_o
//   pending_o      N_REQ  sticky pending vector
//   busy_o         1      pending or offering
//   grant_cnt_o    CNT_W  completed handshakes (wrapping)
interface priority_req_sched_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16,
  parameter int IDX_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req_i;
  logic             grant_ready_i;
  logic             grant_valid_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic [N_REQ-1:0] grant_onehot_o;
  logic [N_REQ-1:0] pending_o;
  logic             busy_o;
  logic [CNT_W-1:0] grant_cnt_o;

  modport slave (
    input  req_i, grant_ready_i,
    output grant_valid_o, grant_idx_o, grant_onehot_o, pending_o, busy_o, grant_cnt_o
  );

  modport master (
    output req_i, grant_ready_i,
    input  grant_valid_o, grant_idx_o, grant_onehot_o, pending_o, busy_o, grant_cnt_o
  );
endinterface

// File: rtl/priority_req_sched.sv
// priority_req_sched
// Collects single-cycle request pulses into sticky pending bits and offers one
// pending source at a time on a valid/ready grant handshake, lowest index first.
// Back-to-back grants are issued one per cycle while work remains.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high
//   bus  priority_req_sched_if.slave (req_i, grant_ready_i in; grant_valid_o,
//        grant_idx_o, grant_onehot_o, pending_o, busy_o, grant_cnt_o out)
// Optional feature macro: PRIO_AGING_EN
//   When defined, each source carries a saturating age counter that counts
//   handshakes it lost while pending; a source at AGE_MAX wins ahead of plain
//   priority (lowest such index first). When undefined, no age logic exists.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no offer outstanding; latch a winner as soon as pending != 0
// ST_OFFER | grant_valid_o high, idx/onehot held until handshake
module priority_req_sched #(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 16,
  parameter int AGE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  priority_req_sched_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || AGE_MAX < 1) begin : g_bad_param
    $error("priority_req_sched: parameter out of range");
  end

  typedef enum logic {ST_IDLE, ST_OFFER} state_t;

  state_t           state_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] pending_d;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [N_REQ-1:0] onehot_q;
  logic [CNT_W-1:0] cnt_q;

  logic             hs;
  logic [N_REQ-1:0] hs_clr;
  logic [N_REQ-1:0] remain;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] age_hit;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_onehot;

  // Walking from the top down lets the lowest set index overwrite last,
  // which is the same decision as an if / else-if chain from index 0.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (v[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  assign hs     = valid_q & bus.grant_ready_i;
  assign hs_clr = hs ? onehot_q : '0;
  // New request on the same bit as the handshake wins: OR after the clear.
  assign remain    = (pending_q & ~hs_clr) | bus.req_i;
  assign pending_d = remain;

  // IDLE arbitrates on the registered pending vector (one cycle after the
  // pulse); a handshake re-arbitrates on what is left plus same-cycle pulses.
  assign cand = (state_q == ST_OFFER) ? remain : pending_q;

`ifdef PRIO_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);

  logic [AGE_W-1:0] age_q [N_REQ];
  logic [AGE_W-1:0] age_d [N_REQ];

  // Updated ages feed the same-cycle decision so the source that just reached
  // AGE_MAX takes the very next grant.
  always_comb begin
    age_hit = '0;
    for (int k = 0; k < N_REQ; k++) begin
      age_d[k] = age_q[k];
      if (hs && onehot_q[k]) begin
        age_d[k] = '0;
      end else if (hs && pending_q[k] && (age_q[k] != AGE_TOP)) begin
        age_d[k] = age_q[k] + AGE_W'(1);
      end
      age_hit[k] = cand[k] && (age_d[k] == AGE_TOP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_REQ; k++) age_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) age_q[k] <= age_d[k];
    end
  end
`else
  assign age_hit = '0;
`endif

  always_comb begin
    if (|age_hit) win_idx = lowest_idx(age_hit);
    else          win_idx = lowest_idx(cand);
    win_onehot = N_REQ'(1) << win_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      onehot_q  <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      if (hs) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (|pending_q) begin
            state_q  <= ST_OFFER;
            valid_q  <= 1'b1;
            idx_q    <= win_idx;
            onehot_q <= win_onehot;
          end
        end
        ST_OFFER: begin
          if (hs) begin
            if (|remain) begin
              idx_q    <= win_idx;
              onehot_q <= win_onehot;
            end else begin
              state_q  <= ST_IDLE;
              valid_q  <= 1'b0;
              idx_q    <= '0;
              onehot_q <= '0;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          valid_q  <= 1'b0;
          idx_q    <= '0;
          onehot_q <= '0;
        end
      endcase
    end
  end

  assign bus.grant_valid_o  = valid_q;
  assign bus.grant_idx_o    = idx_q;
  assign bus.grant_onehot_o = onehot_q;
  assign bus.pending_o      = pending_q;
  assign bus.busy_o         = (|pending_q) | valid_q;
  assign bus.grant_cnt_o    = cnt_q;
endmodule

// File: tb/tb_priority_req_sched.sv
module tb_priority_req_sched;
  localparam int N       = 4;
  localparam int CNT_W   = 16;
  localparam int AGE_MAX = 2;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  priority_req_sched_if #(.N_REQ(N), .CNT_W(CNT_W)) bus ();

  priority_req_sched #(.N_REQ(N), .CNT_W(CNT_W), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays following the scheduling rules.
  int m_pend [N];
  int m_age  [N];
  int m_valid;
  int m_idx;
  int m_cnt;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 0;
      m_age[k]  = 0;
    end
    m_valid = 0;
    m_idx   = 0;
    m_cnt   = 0;
  endfunction

  function automatic int model_pick();
    int res;
    res = -1;
`ifdef PRIO_AGING_EN
    for (int k = 0; k < N; k++) begin
      if (res < 0 && m_pend[k] != 0 && m_age[k] == AGE_MAX) res = k;
    end
`endif
    for (int k = 0; k < N; k++) begin
      if (res < 0 && m_pend[k] != 0) res = k;
    end
    return res;
  endfunction

  function automatic void model_step(input logic [N-1:0] req, input logic rdy);
    int hs;
    int idle_pick;
    hs = (m_valid != 0 && rdy) ? 1 : 0;
    idle_pick = model_pick();
    if (hs != 0) begin
`ifdef PRIO_AGING_EN
      for (int k = 0; k < N; k++) begin
        if (k != m_idx && m_pend[k] != 0 && m_age[k] < AGE_MAX) m_age[k]++;
      end
      m_age[m_idx] = 0;
`endif
      m_pend[m_idx] = 0;
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    for (int k = 0; k < N; k++) begin
      if (req[k]) m_pend[k] = 1;
    end
    if (m_valid == 0) begin
      if (idle_pick >= 0) begin
        m_valid = 1;
        m_idx   = idle_pick;
      end
    end else if (hs != 0) begin
      if (model_pick() >= 0) m_idx = model_pick();
      else                   m_valid = 0;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] req, input logic rdy);
    bus.req_i         = req;
    bus.grant_ready_i = rdy;
    @(posedge clk);
    #1;
    model_step(req, rdy);
  endtask

  task automatic chk_model(input string tag);
    int pv;
    pv = 0;
    for (int k = 0; k < N; k++) if (m_pend[k] != 0) pv |= (1 << k);
    chk({tag, " valid"},   int'(bus.grant_valid_o),  m_valid);
    chk({tag, " idx"},     int'(bus.grant_idx_o),    (m_valid != 0) ? m_idx : 0);
    chk({tag, " onehot"},  int'(bus.grant_onehot_o), (m_valid != 0) ? (1 << m_idx) : 0);
    chk({tag, " pending"}, int'(bus.pending_o),      pv);
    chk({tag, " busy"},    int'(bus.busy_o),         (pv != 0 || m_valid != 0) ? 1 : 0);
    chk({tag, " cnt"},     int'(bus.grant_cnt_o),    m_cnt);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         rdy;
    logic         exp_valid;
    int           exp_idx;
    logic [N-1:0] exp_pend;
    int           exp_cnt;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int exp_oh;
    logic [N-1:0] rq;
    vectors     = 0;
    miscompares = 0;
    model_reset();

    // single request, priority ordering, back-pressure, set/clear collision
    tbl[0]  = '{4'b0100, 1'b1, 1'b0, 0, 4'b0100, 0};
    tbl[1]  = '{4'b0000, 1'b1, 1'b1, 2, 4'b0100, 0};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000, 1};
    tbl[3]  = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000, 1};
    tbl[4]  = '{4'b1011, 1'b1, 1'b0, 0, 4'b1011, 1};
    tbl[5]  = '{4'b0000, 1'b1, 1'b1, 0, 4'b1011, 1};
    tbl[6]  = '{4'b0000, 1'b1, 1'b1, 1, 4'b1010, 2};
    tbl[7]  = '{4'b0000, 1'b1, 1'b1, 3, 4'b1000, 3};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000, 4};
    tbl[9]  = '{4'b1000, 1'b0, 1'b0, 0, 4'b1000, 4};
    tbl[10] = '{4'b0001, 1'b0, 1'b1, 3, 4'b1001, 4};
    tbl[11] = '{4'b0001, 1'b0, 1'b1, 3, 4'b1001, 4};
    tbl[12] = '{4'b0001, 1'b0, 1'b1, 3, 4'b1001, 4};
    tbl[13] = '{4'b0001, 1'b0, 1'b1, 3, 4'b1001, 4};
    tbl[14] = '{4'b0001, 1'b0, 1'b1, 3, 4'b1001, 4};
    tbl[15] = '{4'b0000, 1'b1, 1'b1, 0, 4'b0001, 5};
    tbl[16] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000, 6};
    tbl[17] = '{4'b0010, 1'b1, 1'b0, 0, 4'b0010, 6};
    tbl[18] = '{4'b0000, 1'b1, 1'b1, 1, 4'b0010, 6};
    tbl[19] = '{4'b0010, 1'b1, 1'b1, 1, 4'b0010, 7};
    tbl[20] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000, 8};

    rst               = 1'b1;
    bus.req_i         = '0;
    bus.grant_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid",   int'(bus.grant_valid_o),  0);
    chk("reset onehot",  int'(bus.grant_onehot_o), 0);
    chk("reset pending", int'(bus.pending_o),      0);
    chk("reset busy",    int'(bus.busy_o),         0);
    chk("reset cnt",     int'(bus.grant_cnt_o),    0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].req, tbl[i].rdy);
      exp_oh = tbl[i].exp_valid ? (1 << tbl[i].exp_idx) : 0;
      chk($sformatf("tbl%0d valid", i),   int'(bus.grant_valid_o),  int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d idx", i),     int'(bus.grant_idx_o),    tbl[i].exp_idx);
      chk($sformatf("tbl%0d onehot", i),  int'(bus.grant_onehot_o), exp_oh);
      chk($sformatf("tbl%0d pending", i), int'(bus.pending_o),      int'(tbl[i].exp_pend));
      chk($sformatf("tbl%0d busy", i),    int'(bus.busy_o),
          (tbl[i].exp_pend != 0 || tbl[i].exp_valid) ? 1 : 0);
      chk($sformatf("tbl%0d cnt", i),     int'(bus.grant_cnt_o),    tbl[i].exp_cnt);
    end

    // asynchronous reset in the middle of an offer
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    chk("pre-reset valid", int'(bus.grant_valid_o), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst valid",   int'(bus.grant_valid_o),  0);
    chk("async rst onehot",  int'(bus.grant_onehot_o), 0);
    chk("async rst idx",     int'(bus.grant_idx_o),    0);
    chk("async rst pending", int'(bus.pending_o),      0);
    chk("async rst busy",    int'(bus.busy_o),         0);
    chk("async rst cnt",     int'(bus.grant_cnt_o),    0);
    model_reset();
    bus.grant_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("rst held cnt", int'(bus.grant_cnt_o), 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef PRIO_AGING_EN
    // source 3 waits while source 0 is re-pulsed; it wins after two grants to 0
    step(4'b1001, 1'b1);
    step(4'b0001, 1'b1);
    chk("age first 0", int'(bus.grant_idx_o), 0);
    step(4'b0001, 1'b1);
    chk("age second 0", int'(bus.grant_idx_o), 0);
    step(4'b0001, 1'b1);
    chk("age grant 3", int'(bus.grant_idx_o), 3);
    chk_model("age");
    repeat (4) begin
      step(4'b0000, 1'b1);
      chk_model("age drain");
    end
`endif

    for (int c = 0; c < 600; c++) begin
      rq = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step(rq, ($urandom_range(0, 3) != 0));
      chk_model("rand");
    end

    for (int c = 0; c < 8; c++) begin
      step(4'b0000, 1'b1);
      chk_model("drain");
    end
    chk("final busy", int'(bus.busy_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
